// File: rtl/flappy_pkg.sv
// flappy_pkg: types and screen constants shared by the game-rule blocks.
//   game_state_t : game FSM state encoding (IDLE, PLAY, DYING, OVER)
//   bcd3_t       : three packed BCD digits, hundreds in [11:8]
//   SCREEN_W/H   : visible screen size in pixels
package flappy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } game_state_t;

    typedef logic [11:0] bcd3_t;

    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

endpackage

// File: rtl/bcd3_counter.sv
// bcd3_counter: three-digit packed-BCD counter that saturates at 999.
//   clk   : system clock
//   reset : synchronous, active-high; clears the count
//   clr   : clear the count (wins over inc)
//   inc   : add one, with decimal carry; no effect at 999
//   q     : current count, registered
module bcd3_counter
    import flappy_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  logic  inc,
    output bcd3_t q
);

    bcd3_t q_q;
    bcd3_t q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (inc && (q_q != 12'h999)) begin
            if (q_q[3:0] != 4'd9) begin
                q_d[3:0] = q_q[3:0] + 4'd1;
            end else begin
                q_d[3:0] = 4'd0;
                if (q_q[7:4] != 4'd9) begin
                    q_d[7:4] = q_q[7:4] + 4'd1;
                end else begin
                    // Hundreds cannot be 9 here: 999 was excluded above.
                    q_d[7:4]  = 4'd0;
                    q_d[11:8] = q_q[11:8] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/collision_score.sv
// collision_score: game-rule engine. On each movement tick during play it
// checks the bird against the current pipe and the floor, counts pipes
// cleared, and steps the IDLE/PLAY/DYING/OVER game FSM.
//   clk, reset          : clock, synchronous active-high reset
//   start               : one-cycle start pulse (already edge-detected)
//   tick                : one-cycle movement-step enable
//   bird_y              : top row of the bird
//   pipe_x              : left column of the pipe
//   pipe_y1, pipe_y0    : gap spans rows pipe_y1 .. pipe_y0-1
//   run                 : high in PLAY (drives the pipe generator start)
//   hit, scored         : one-cycle pulses for collision / pipe cleared
//   game_over           : high in OVER
//   score_bcd, hi_bcd   : current and best score, three BCD digits
// All outputs come straight from flops.
module collision_score
    import flappy_pkg::*;
#(
    parameter int N           = 11,
    parameter int BIRD_X      = 100,
    parameter int BIRD_SIZE   = 15,
    parameter int PIPE_WIDTH  = 40,
    parameter int SCREEN_H    = flappy_pkg::SCREEN_H,
    parameter int DEATH_TICKS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         tick,
    input  logic [N-1:0] bird_y,
    input  logic [N-1:0] pipe_x,
    input  logic [N-1:0] pipe_y1,
    input  logic [N-1:0] pipe_y0,
    output logic         run,
    output logic         hit,
    output logic         scored,
    output logic         game_over,
    output logic [11:0]  score_bcd,
    output logic [11:0]  hi_bcd
);

    localparam int CNT_W = $clog2(DEATH_TICKS + 1);

    // All geometry is evaluated one bit wider than the coordinates so that
    // sums such as pipe_x+PIPE_WIDTH never wrap.
    localparam logic [N:0] BIRD_L    = (N+1)'(BIRD_X);
    localparam logic [N:0] BIRD_R    = (N+1)'(BIRD_X + BIRD_SIZE - 1);
    localparam logic [N:0] BSZ       = (N+1)'(BIRD_SIZE);
    localparam logic [N:0] PW        = (N+1)'(PIPE_WIDTH);
    localparam logic [N:0] PW_M1     = (N+1)'(PIPE_WIDTH - 1);
    localparam logic [N:0] FLOOR     = (N+1)'(SCREEN_H);
    localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_TICKS);

    game_state_t      state_q, state_d;
    logic [N-1:0]     prev_x_q, prev_x_d;
    logic [CNT_W-1:0] death_q, death_d;
    logic             hit_q, hit_d;
    logic             scored_q, scored_d;
    logic             run_q, run_d;
    logic             game_over_q, game_over_d;
    bcd3_t            hi_q, hi_d;
    bcd3_t            score;
    logic             score_clr, score_inc;

    logic [N:0] px_w, prev_w, by_w, y0_w, y1_w;
    logic       overlap, pipe_hit, floor_hit, collision, pass;

    always_comb begin
        px_w   = {1'b0, pipe_x};
        prev_w = {1'b0, prev_x_q};
        by_w   = {1'b0, bird_y};
        y0_w   = {1'b0, pipe_y0};
        y1_w   = {1'b0, pipe_y1};

        overlap   = (px_w <= BIRD_R) && ((px_w + PW_M1) >= BIRD_L);
        pipe_hit  = overlap && ((by_w < y1_w) || ((by_w + BSZ) > y0_w));
        floor_hit = (by_w + BSZ) > FLOOR;
        collision = pipe_hit || floor_hit;
        // The pipe's right edge moved from the bird's side to fully past its
        // left column. Requiring a leftward move rejects the 0->640 wrap.
        pass = ((prev_w + PW) > BIRD_L) && ((px_w + PW) <= BIRD_L) &&
               (px_w < prev_w);
    end

    always_comb begin
        state_d   = state_q;
        prev_x_d  = prev_x_q;
        death_d   = death_q;
        hit_d     = 1'b0;
        scored_d  = 1'b0;
        hi_d      = hi_q;
        score_clr = 1'b0;
        score_inc = 1'b0;

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    score_clr = 1'b1;
                    // Seed prev_x so the first PLAY tick can never score.
                    prev_x_d  = pipe_x;
                    state_d   = ST_PLAY;
                end
            end
            ST_PLAY: begin
                if (tick) begin
                    prev_x_d = pipe_x;
                    if (collision) begin
                        hit_d   = 1'b1;
                        death_d = DEATH_LOAD;
                        state_d = ST_DYING;
                        // Packed BCD orders the same as binary.
                        if (score > hi_q) hi_d = score;
                    end else if (pass) begin
                        scored_d  = 1'b1;
                        score_inc = 1'b1;
                    end
                end
            end
            ST_DYING: begin
                if (tick) begin
                    if (death_q <= CNT_W'(1)) begin
                        death_d = '0;
                        state_d = ST_OVER;
                    end else begin
                        death_d = death_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        run_d       = (state_d == ST_PLAY);
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            prev_x_q    <= '0;
            death_q     <= '0;
            hit_q       <= 1'b0;
            scored_q    <= 1'b0;
            run_q       <= 1'b0;
            game_over_q <= 1'b0;
            hi_q        <= '0;
        end else begin
            state_q     <= state_d;
            prev_x_q    <= prev_x_d;
            death_q     <= death_d;
            hit_q       <= hit_d;
            scored_q    <= scored_d;
            run_q       <= run_d;
            game_over_q <= game_over_d;
            hi_q        <= hi_d;
        end
    end

    bcd3_counter u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (score_clr),
        .inc   (score_inc),
        .q     (score)
    );

    assign run       = run_q;
    assign hit       = hit_q;
    assign scored    = scored_q;
    assign game_over = game_over_q;
    assign score_bcd = score;
    assign hi_bcd    = hi_q;

endmodule

// File: tb/tb_collision_score.sv
// tb_collision_score: directed stimulus for collision_score. Each driven
// cycle pushes the hand-computed output snapshot expected after that edge;
// an independent monitor pops and compares on the falling edge.
module tb_collision_score;

    localparam int N = 11;
    localparam int W = 28;   // run, hit, scored, game_over, score[12], hi[12]

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         tick = 1'b0;
    logic [N-1:0] bird_y = '0;
    logic [N-1:0] pipe_x = '0;
    logic [N-1:0] pipe_y1 = 11'd225;
    logic [N-1:0] pipe_y0 = 11'd255;
    logic         run, hit, scored, game_over;
    logic [11:0]  score_bcd, hi_bcd;

    collision_score dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tick      (tick),
        .bird_y    (bird_y),
        .pipe_x    (pipe_x),
        .pipe_y1   (pipe_y1),
        .pipe_y0   (pipe_y0),
        .run       (run),
        .hit       (hit),
        .scored    (scored),
        .game_over (game_over),
        .score_bcd (score_bcd),
        .hi_bcd    (hi_bcd)
    );

    // ---------------- clock / cycle count ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int           due_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    function automatic logic [11:0] to_bcd(input int v);
        logic [11:0] r;
        r[11:8] = 4'((v / 100) % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[3:0]  = 4'(v % 10);
        return r;
    endfunction

    always @(negedge clk) begin
        if (due_q.size() > 0 && due_q[0] == cyc) begin
            logic [W-1:0] e, a;
            string        nm;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            void'(due_q.pop_front());
            a  = {run, hit, scored, game_over, score_bcd, hi_bcd};
            checks = checks + 1;
            if (a !== e) begin
                errors = errors + 1;
                $display("FAIL %s @cyc %0d: got run=%b hit=%b scored=%b go=%b score=%h hi=%h, want run=%b hit=%b scored=%b go=%b score=%h hi=%h",
                         nm, cyc, a[27], a[26], a[25], a[24], a[23:12], a[11:0],
                         e[27], e[26], e[25], e[24], e[23:12], e[11:0]);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input string nm, input bit rs, input bit st, input bit tk,
                        input int by, input int px,
                        input bit e_run, input bit e_hit, input bit e_sc, input bit e_go,
                        input int e_score, input int e_hi);
        @(negedge clk);
        reset  = rs;
        start  = st;
        tick   = tk;
        bird_y = N'(by);
        pipe_x = N'(px);
        exp_q.push_back({e_run, e_hit, e_sc, e_go, to_bcd(e_score), to_bcd(e_hi)});
        due_q.push_back(cyc + 1);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        start = 1'b0;
        tick  = 1'b0;
        reset = 1'b0;
    endtask

    // PLAY tick with a safe bird (row 240 inside the 225..255 gap).
    task automatic ptick(input string nm, input int px, input bit e_sc,
                         input int e_score, input int e_hi);
        step(nm, 0, 0, 1, 240, px, 1, 0, e_sc, 0, e_score, e_hi);
    endtask

    task automatic go_play(input string nm, input int px, input int e_hi);
        step(nm, 0, 1, 0, 240, px, 1, 0, 0, 0, 0, e_hi);
    endtask

    // Eight DYING ticks: OVER only after the last one.
    task automatic die(input string nm, input int sc, input int hi);
        for (int i = 1; i <= 8; i++)
            step(nm, 0, 0, 1, 240, 300, 0, 0, 0, (i == 8), sc, hi);
    endtask

    // n passes using a 61 -> 60 step each time.
    task automatic passes(input string nm, input int n, input int base, input int hi);
        for (int i = 1; i <= n; i++) begin
            ptick(nm, 60, 1, base + i, hi);
            ptick(nm, 61, 0, base + i, hi);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        step("reset0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("reset1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("idle", 0, 0, 1, 240, 130, 0, 0, 0, 0, 0, 0);

        // Start, then safe passage 130 -> 60
        go_play("start", 130, 0);
        for (int px = 129; px >= 61; px--) ptick("safe", px, 0, 0, 0);
        ptick("pass_61_60", 60, 1, 1, 0);

        // Pipe hit from below, start ignored while dying, then OVER
        step("hit_low", 0, 0, 1, 241, 90, 0, 1, 0, 0, 1, 1);
        step("dying_start", 0, 1, 0, 240, 90, 0, 0, 0, 0, 1, 1);
        die("dying_a", 1, 1);
        step("over_tick", 0, 0, 1, 240, 90, 0, 0, 0, 1, 1, 1);

        // Restart from OVER, pipe hit from above; hi unchanged
        go_play("restart", 100, 1);
        step("hit_high", 0, 0, 1, 224, 99, 0, 1, 0, 0, 0, 1);
        die("dying_b", 0, 1);

        // Floor: 465 is the last safe row
        go_play("start_floor", 300, 1);
        step("floor_ok", 0, 0, 1, 465, 299, 1, 0, 0, 0, 0, 1);
        step("floor_hit", 0, 0, 1, 466, 298, 0, 1, 0, 0, 0, 1);
        die("dying_c", 0, 1);

        // Wrap never scores; pass together with collision gives hit only
        go_play("start_wrap", 2, 1);
        ptick("wrap_1", 1, 0, 0, 1);
        ptick("wrap_0", 0, 0, 0, 1);
        ptick("wrap_640", 640, 0, 0, 1);
        ptick("wrap_639", 639, 0, 0, 1);
        ptick("wrap_61", 61, 0, 0, 1);
        ptick("wrap_pass", 60, 1, 1, 1);
        ptick("wrap_61b", 61, 0, 1, 1);
        step("pass_and_hit", 0, 0, 1, 470, 60, 0, 1, 0, 0, 1, 1);
        die("dying_d", 1, 1);

        // Saturation at 999
        go_play("start_sat", 61, 1);
        passes("count", 999, 0, 1);
        ptick("sat_pass", 60, 1, 999, 1);
        step("sat_hit", 0, 0, 1, 470, 200, 0, 1, 0, 0, 999, 999);
        die("dying_e", 999, 999);

        // Mid-game reset clears everything, including hi
        go_play("start_five", 61, 999);
        passes("five", 5, 0, 999);
        step("mid_reset", 1, 0, 0, 240, 61, 0, 0, 0, 0, 0, 0);
        step("after_reset", 0, 0, 1, 240, 61, 0, 0, 0, 0, 0, 0);

        // Game of 3 then game of 2: best stays 3
        go_play("start_g3", 61, 0);
        passes("g3", 3, 0, 0);
        step("g3_hit", 0, 0, 1, 470, 200, 0, 1, 0, 0, 3, 3);
        die("dying_g3", 3, 3);
        go_play("start_g2", 61, 3);
        passes("g2", 2, 0, 3);
        step("g2_hit", 0, 0, 1, 470, 200, 0, 1, 0, 0, 2, 3);
        die("dying_g2", 2, 3);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: %0d expected responses never compared, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        errors = errors + 1;
        $display("FAIL watchdog: run did not complete by %0t, want completion", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/collision_score.md
# collision_score

Game-rule engine on the consumer side of the pipe generator. It samples the current pipe (`pipe_x`, `pipe_y0`, `pipe_y1`) and the bird's vertical position once per movement step. It detects collisions, counts pipes cleared, and runs the game-state FSM. Its `run` output drives the pipe generator's `start` input, and its BCD scores feed the seven-segment display.

## Interface
- `N`, 11: coordinate width. Matches the pipe generator.
- `BIRD_X`, 100: left column of the bird (fixed).
- `BIRD_SIZE`, 15: bird is a square of this side, in pixels.
- `PIPE_WIDTH`, 40: pipe occupies columns `pipe_x` .. `pipe_x+PIPE_WIDTH-1`.
- `SCREEN_H`, 480: floor row. Row `SCREEN_H-1` is the last visible row.
- `DEATH_TICKS`, 8: number of `tick` pulses spent in the DYING state.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high. Clears everything, including `hi_bcd`.
- `start` in 1: one-cycle pulse, already edge-detected upstream.
- `tick` in 1: one-cycle pulse per movement step. This is the same enable that steps the pipe.
- `bird_y` in N: top row of the bird.
- `pipe_x` in N: left column of the pipe.
- `pipe_y1` in N: bottom row+1 of the upper pipe. The gap starts at this row.
- `pipe_y0` in N: top row of the lower pipe. `pipe_y0 > pipe_y1`.
- `run` out 1: high in PLAY only.
- `hit` out 1: one-cycle pulse on collision.
- `scored` out 1: one-cycle pulse on pipe cleared.
- `game_over` out 1: high in OVER.
- `score_bcd` out 12: three BCD digits of the current game's score.
- `hi_bcd` out 12: three BCD digits of the best score since reset.

## Operation
- **States**: IDLE, PLAY, DYING, OVER. Reset state is IDLE.
- **IDLE** and **OVER**:
  - On `start`: `score_bcd` is cleared to 0 and the FSM goes to PLAY.
  - `tick` is ignored.
- **PLAY**: evaluation happens only on cycles with `tick`=1. All inputs are sampled on that same edge.
  - **Horizontal overlap**: `pipe_x <= BIRD_X+BIRD_SIZE-1` and `pipe_x+PIPE_WIDTH-1 >= BIRD_X`. Compute at N+1 bits; there is no wrap.
  - **Pipe hit**: overlap and (`bird_y < pipe_y1` or `bird_y+BIRD_SIZE > pipe_y0`).
  - **Floor hit**: `bird_y+BIRD_SIZE > SCREEN_H`. Applies regardless of overlap.
  - **Collision**: pulse `hit`, load the death counter with `DEATH_TICKS`, and go to DYING.
  - **Pass**: `prev_x+PIPE_WIDTH > BIRD_X` and `pipe_x+PIPE_WIDTH <= BIRD_X` and `pipe_x < prev_x`. `prev_x` is the `pipe_x` captured at the previous PLAY `tick`.
  - **On pass**: pulse `scored` and apply a BCD increment to `score_bcd`.
  - **`prev_x` init**: on entry to PLAY it loads `pipe_x`, so the first tick never scores.
- **Pipe wrap**: `pipe_x` jumps from 0 to 640, so `pipe_x > prev_x`. This never scores.
- **Collision and pass on the same tick**: collision wins. No `scored` pulse and no increment.
- **BCD increment**: digit carry at 9. The count saturates at 999; further passes still pulse `scored` but do not change the value.
- **DYING**: each `tick` decrements the counter. At 0, go to OVER. `start` is ignored.
- **High score**: on the PLAY→DYING transition, if `score_bcd > hi_bcd` then `hi_bcd <= score_bcd`. Packed-BCD unsigned compare is valid.
- **Reset mid-game**: everything returns to IDLE, all outputs go to 0, and `hi_bcd` is lost.

## Timing
- **Reset values**: `run`=0, `hit`=0, `scored`=0, `game_over`=0, `score_bcd`=0, `hi_bcd`=0, state IDLE.
- **`start` edge at cycle t**: `run`=1 from t+1.
- **`tick` at edge t with collision**:
  - `hit`=1 and `run`=0 during t+1 only.
  - `hi_bcd` is updated at t+1.
- **`tick` at edge t with pass**: `scored`=1 and the new `score_bcd` are both visible at t+1.
- **End of DYING**: the `DEATH_TICKS`-th tick in DYING at edge t gives `game_over`=1 from t+1.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- **`flappy_pkg`**:
  - state enum `game_state_t`.
  - `bcd3_t` (`logic [11:0]`).
  - constants `SCREEN_W`=640 and `SCREEN_H`=480.
- **Sub-module `bcd3_counter`**:
  - Ports: `clk`, `reset`, `clr`, `inc`, `q`.
  - Behaviour: three-digit saturating BCD counter.
- **Top**: instantiates one `bcd3_counter` and holds the FSM, the collision/pass compare logic, the `prev_x` and death-counter registers, and `hi_bcd`.

## Test plan
- **Reset/start**: after reset all outputs are 0; a `start` pulse gives `run`=1 the next cycle, with `score_bcd`=0x000.
- **Safe passage**: `pipe_y1`=225, `pipe_y0`=255, `bird_y`=240. Ticks with `pipe_x` stepping 130→60 give no `hit`. The step `pipe_x` 61→60 gives `scored`=1 and `score_bcd`=0x001.
- **Pipe hit**:
  - Same pipe, `bird_y`=241, `pipe_x`=90, tick → `hit` pulse, `run`=0.
  - 8 more ticks → `game_over`=1 and `hi_bcd`=0x001.
  - Repeat with `bird_y`=224 → `hit`.
- **Floor and wrap**:
  - `bird_y`=466 with no pipe overlap → `hit`.
  - `pipe_x` stepping 0→640 → no `scored`.
- **Simultaneous and saturation**:
  - A tick that is both a pass and a pipe hit → `hit` only, score unchanged.
  - Preload to 0x999 via 999 passes; the next pass → `scored`=1, `score_bcd` stays 0x999.
- **Mid-game reset and replay**:
  - Reset during PLAY with `score_bcd`=0x005 → everything is 0, including `hi_bcd`.
  - A game scoring 3 and then a game scoring 2 → `hi_bcd`=0x003.
